// File: rtl/ImageProcessingPkg.sv
// Shared types for the ImageProcessor core and its request scheduler.
// The scheduler only carries instruction_t and pixelMatrix_t words through as opaque vectors.
package ImageProcessingPkg;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ADD = 3'd1,
        SUB = 3'd2,
        MAX = 3'd3,
        MIN = 3'd4
    } opcodes_t;

    typedef logic [23:0] pixel_t;
    typedef logic [2:0][2:0][23:0] pixelMatrix_t;

    typedef struct packed {
        opcodes_t     opcode;
        pixelMatrix_t cellA;
        pixelMatrix_t cellB;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } sched_state_t;

    localparam int IW_W  = $bits(instruction_t);
    localparam int PM_W  = $bits(pixelMatrix_t);
    localparam int LAT_W = 4;

    function automatic pixelMatrix_t fill_matrix(input pixel_t p);
        return {9{p}};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set bit of req at or after ptr,
// wrapping past NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    always_comb begin
        int               slot;
        logic [IDX_W-1:0] idx;
        // NOTE: every output gets a value before the search so no path leaves one unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        slot      = 0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = int'(ptr) + i;
            if (slot >= NUM_REQ) slot -= NUM_REQ;
            idx = IDX_W'(slot);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/ip_core_scheduler.sv
// Shares one ImageProcessor core between NUM_REQ requesters, one transaction at a time:
// accept -> hold IW for the core latency -> capture result -> return it tagged with the winner.
module ip_core_scheduler
    import ImageProcessingPkg::*;
#(
    parameter int  NUM_REQ      = 4,
    parameter int  CORE_LATENCY = 1,
    localparam int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][IW_W-1:0]   req_iw,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [IW_W-1:0]                core_iw,
    input  logic [PM_W-1:0]                core_result,
    output logic                           rsp_valid,
    output logic [IDX_W-1:0]               rsp_id,
    output logic [PM_W-1:0]                rsp_result,
    input  logic                           rsp_ready,
    output logic                           busy
);

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] id_q, id_d;
    logic [IW_W-1:0]  iw_q, iw_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [PM_W-1:0]  rsp_result_q, rsp_result_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        iw_d         = iw_q;
        lat_cnt_d    = lat_cnt_q;
        rsp_result_d = rsp_result_q;

        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    iw_d    = req_iw[grant_idx];
                    id_d    = grant_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                lat_cnt_d = LAT_W'(CORE_LATENCY - 1);
                state_d   = WAIT;
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    rsp_result_d = core_result;
                    state_d      = RESPOND;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = (id_q == IDX_W'(NUM_REQ - 1)) ? '0 : id_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        rsp_valid_d = (state_d == RESPOND);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            iw_q         <= '0;
            lat_cnt_q    <= '0;
            rsp_result_q <= '0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            iw_q         <= iw_d;
            lat_cnt_q    <= lat_cnt_d;
            rsp_result_q <= rsp_result_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    // iw_q only changes on acceptance, so the core sees a constant IW until the next grant.
    assign core_iw    = iw_q;
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_valid  = rsp_valid_q;
    assign busy       = busy_q;
    assign req_ready  = (state_q == IDLE && reset_n) ? grant : '0;

endmodule

// File: tb/tb_ip_core_scheduler.sv
// Directed bench for ip_core_scheduler with a small behavioural ImageProcessor model
// (ADD = per-pixel sum of cellA and cellB, other opcodes pass cellA through).
module tb_ip_core_scheduler;
    import ImageProcessingPkg::*;

    localparam int NUM_REQ      = 4;
    localparam int CORE_LATENCY = 1;
    localparam int IDX_W        = 2;
    localparam int CW           = 448;

    logic                         clk = 1'b0;
    logic                         reset_n = 1'b1;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0][IW_W-1:0] req_iw;
    logic [NUM_REQ-1:0]           req_ready;
    logic [IW_W-1:0]              core_iw;
    logic [PM_W-1:0]              core_result;
    logic                         rsp_valid;
    logic [IDX_W-1:0]             rsp_id;
    logic [PM_W-1:0]              rsp_result;
    logic                         rsp_ready;
    logic                         busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ip_core_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .CORE_LATENCY (CORE_LATENCY)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_iw      (req_iw),
        .req_ready   (req_ready),
        .core_iw     (core_iw),
        .core_result (core_result),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_ready   (rsp_ready),
        .busy        (busy)
    );

    function automatic logic [PM_W-1:0] core_fn(input logic [IW_W-1:0] w);
        instruction_t    ins;
        logic [PM_W-1:0] a, b, r;
        ins = w;
        a   = ins.cellA;
        b   = ins.cellB;
        r   = a;
        if (ins.opcode == ADD)
            for (int k = 0; k < 9; k++) r[k*24 +: 24] = a[k*24 +: 24] + b[k*24 +: 24];
        return r;
    endfunction

    logic [PM_W-1:0] core_pipe [CORE_LATENCY];
    always @(posedge clk) begin
        core_pipe[0] <= core_fn(core_iw);
        for (int i = 1; i < CORE_LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_result = core_pipe[CORE_LATENCY-1];

    function automatic logic [IW_W-1:0] make_iw(input opcodes_t op, input pixel_t a, input pixel_t b);
        instruction_t ins;
        ins.opcode = op;
        ins.cellA  = fill_matrix(a);
        ins.cellB  = fill_matrix(b);
        return ins;
    endfunction

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        int idx;
        idx = -1;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) idx = i;
        return idx;
    endfunction

    task automatic check(input string tag, input logic [CW-1:0] observed, input logic [CW-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [IW_W-1:0] iw_a, iw_r, iw_s, iw_c;
        int              n, got, cyc;
        int              ids [5];
        int              tms [5];

        req_valid = '0;
        req_iw    = '0;
        rsp_ready = 1'b1;

        // Reset state, with requests present to prove req_ready is masked.
        #2 reset_n = 1'b0;
        step();
        step();
        req_valid = '1;
        #1;
        check("rst_req_ready",  CW'(req_ready),  CW'(0));
        check("rst_rsp_valid",  CW'(rsp_valid),  CW'(0));
        check("rst_busy",       CW'(busy),       CW'(0));
        check("rst_core_iw",    CW'(core_iw),    CW'(0));
        check("rst_rsp_id",     CW'(rsp_id),     CW'(0));
        check("rst_rsp_result", CW'(rsp_result), CW'(0));
        req_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Single request from requester 2.
        iw_a      = make_iw(ADD, 24'h000000, 24'h00FF00);
        req_iw[2] = iw_a;
        req_valid = 4'b0100;
        #1;
        check("single_ready", CW'(req_ready), CW'(4'b0100));
        check("single_idle_busy", CW'(busy), CW'(0));
        step();
        req_valid = '0;
        #1;
        check("single_ready_after", CW'(req_ready), CW'(0));
        check("single_busy", CW'(busy), CW'(1));
        check("single_core_iw", CW'(core_iw), CW'(iw_a));
        wait_rsp(n);
        check("single_latency", CW'(n), CW'(CORE_LATENCY + 1));
        check("single_rsp_id", CW'(rsp_id), CW'(2));
        check("single_rsp_result", CW'(rsp_result), CW'(fill_matrix(24'h00FF00)));
        step();
        check("single_pulse", CW'(rsp_valid), CW'(0));
        check("single_idle", CW'(busy), CW'(0));

        // Reset during WAIT; rr_ptr is 3 so requester 3 wins first.
        iw_r      = make_iw(SUB, 24'h123456, 24'h111111);
        iw_s      = make_iw(ADD, 24'h010101, 24'h020202);
        req_iw[1] = iw_r;
        req_iw[3] = iw_s;
        req_valid = 4'b1010;
        #1;
        check("rstw_ready", CW'(req_ready), CW'(4'b1000));
        step();
        step();
        check("rstw_in_wait", CW'(busy), CW'(1));
        #1 reset_n = 1'b0;
        #1;
        check("rstw_rsp_valid",  CW'(rsp_valid),  CW'(0));
        check("rstw_busy",       CW'(busy),       CW'(0));
        check("rstw_core_iw",    CW'(core_iw),    CW'(0));
        check("rstw_rsp_id",     CW'(rsp_id),     CW'(0));
        check("rstw_rsp_result", CW'(rsp_result), CW'(0));
        check("rstw_req_ready",  CW'(req_ready),  CW'(0));
        step();
        step();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rstw_ptr0_ready", CW'(req_ready), CW'(4'b0010));
        check("rstw_no_stale", CW'(rsp_valid), CW'(0));
        step();
        req_valid = 4'b1000;
        wait_rsp(n);
        check("rstw_latency", CW'(n), CW'(CORE_LATENCY + 1));
        check("rstw_rsp_id", CW'(rsp_id), CW'(1));
        check("rstw_rsp_result", CW'(rsp_result), CW'(fill_matrix(24'h123456)));
        step();

        // Sparse: only requester 3 valid, rr_ptr is 2.
        #1;
        check("sparse_ready", CW'(req_ready), CW'(4'b1000));
        step();
        req_valid = '0;
        wait_rsp(n);
        check("sparse_rsp_id", CW'(rsp_id), CW'(3));
        check("sparse_rsp_result", CW'(rsp_result), CW'(fill_matrix(24'h030303)));
        step();

        // Round robin with all requesters valid, rr_ptr back at 0.
        for (int i = 0; i < NUM_REQ; i++) req_iw[i] = make_iw(ADD, pixel_t'(i), 24'h000100);
        req_valid = '1;
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 100) begin
            #1;
            if (|(req_valid & req_ready)) begin
                ids[got] = onehot_idx(req_ready);
                tms[got] = cyc;
                got++;
            end
            if (got < 5) begin
                step();
                cyc++;
            end
        end
        check("rr_grant_count", CW'(got), CW'(5));
        check("rr_order_0", CW'(ids[0]), CW'(0));
        check("rr_order_1", CW'(ids[1]), CW'(1));
        check("rr_order_2", CW'(ids[2]), CW'(2));
        check("rr_order_3", CW'(ids[3]), CW'(3));
        check("rr_order_4", CW'(ids[4]), CW'(0));
        for (int i = 1; i < 5; i++) check($sformatf("rr_spacing_%0d", i), CW'(tms[i] - tms[i-1]), CW'(CORE_LATENCY + 3));
        step();
        req_valid = '0;
        wait_rsp(n);
        check("rr_last_rsp_id", CW'(rsp_id), CW'(0));
        check("rr_last_rsp_result", CW'(rsp_result), CW'(fill_matrix(24'h000100)));
        step();

        // IW stability and back-pressure on requester 1 (rr_ptr is 1).
        iw_c      = make_iw(ADD, 24'h000010, 24'h000001);
        req_iw[1] = iw_c;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        check("bp_ready", CW'(req_ready), CW'(4'b0010));
        step();
        req_valid = '0;
        req_iw[1] = make_iw(ADD, 24'h000010, 24'hFF0000);
        #1;
        check("iw_stable_issue", CW'(core_iw), CW'(iw_c));
        step();
        check("iw_stable_wait", CW'(core_iw), CW'(iw_c));
        step();
        check("iw_stable_respond", CW'(core_iw), CW'(iw_c));
        req_valid = '1;
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("bp_rsp_valid_%0d", k),  CW'(rsp_valid),  CW'(1));
            check($sformatf("bp_rsp_id_%0d", k),     CW'(rsp_id),     CW'(1));
            check($sformatf("bp_rsp_result_%0d", k), CW'(rsp_result), CW'(fill_matrix(24'h000011)));
            check($sformatf("bp_req_ready_%0d", k),  CW'(req_ready),  CW'(0));
            step();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        step();
        check("bp_release_idle", CW'(busy), CW'(0));
        check("bp_release_valid", CW'(rsp_valid), CW'(0));
        check("bp_core_iw_hold", CW'(core_iw), CW'(iw_c));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ip_core_scheduler.md
# ip_core_scheduler

Round-robin scheduler that shares one `ImageProcessor` core between `NUM_REQ` requesters. It accepts one instruction word per transaction and drives the core's `IW` input, holding it stable for the core's fixed latency. It then captures the core's `result` and returns it to the winning requester, tagged with that requester's index. It sits between the host/DMA-side instruction sources and the core.

## Interface
- `NUM_REQ`, 4: number of requesters; 2..8.
- `CORE_LATENCY`, 1: cycles from `core_iw` stable at a rising edge to `core_result` valid; 1..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester instruction valid.
- `req_iw`  in  NUM_REQ x $bits(instruction_t)  per-requester instruction word.
- `req_ready`  out  NUM_REQ  one-hot acceptance; a requester is accepted in the cycle where its `req_valid` and `req_ready` are both high.
- `core_iw`  out  $bits(instruction_t)  instruction driven to the core's `IW`.
- `core_result`  in  $bits(pixelMatrix_t)  the core's `result`.
- `rsp_valid`  out  1  response available.
- `rsp_id`  out  $clog2(NUM_REQ)  index of the requester that owns the response.
- `rsp_result`  out  $bits(pixelMatrix_t)  captured core result.
- `rsp_ready`  in  1  consumer accepts the response.
- `busy`  out  1  high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESPOND.
- **IDLE:**
  - The arbiter picks the first requester with `req_valid` high, searching from `rr_ptr` upward with wrap-around.
  - `req_ready` is high only for that winner, combinationally, and only in IDLE.
  - On acceptance, the FSM latches `req_iw[winner]` into `iw_q`, latches the winner into `id_q`, and goes to ISSUE.
  - If no `req_valid` is high, all `req_ready` are 0 and the FSM stays in IDLE.
- **ISSUE:**
  - `core_iw` = `iw_q`.
  - `lat_cnt` loads `CORE_LATENCY-1`.
  - The FSM goes to WAIT.
- **WAIT:**
  - `core_iw` holds `iw_q`.
  - `lat_cnt` decrements each cycle.
  - When `lat_cnt`==0, the FSM captures `core_result` into `rsp_result` and goes to RESPOND.
- **RESPOND:**
  - `rsp_valid`=1; `rsp_id`=`id_q`.
  - `rsp_result` and `rsp_id` are stable until the handshake completes.
  - When `rsp_ready` is high, the FSM goes to IDLE and `rr_ptr` is set to `id_q`+1, modulo `NUM_REQ`.
- `core_iw` holds its last issued value in IDLE and RESPOND. The core is never presented with a changing IW between ISSUE and capture.
- Only one transaction is in flight; no instruction is dropped or duplicated.
- `req_iw` of a non-winning requester is ignored. Requesters keep `req_valid` high until accepted.

## Timing
- **Reset (`reset_n` low, at any time including mid-transaction):**
  - FSM returns to IDLE and `rr_ptr`=0.
  - `iw_q`, `core_iw`, `rsp_result`, `id_q`, `rsp_id` and `lat_cnt` all reset to 0.
  - `rsp_valid`=0 and `busy`=0; `req_ready` is held at 0 while `reset_n` is low.
  - Any in-flight transaction is discarded with no response.
- **Latency:** acceptance edge (IDLE→ISSUE) to `rsp_valid` rising is `CORE_LATENCY`+1 cycles.
- **Throughput:**
  - Minimum period is `CORE_LATENCY`+3 cycles per instruction when `rsp_ready` is held high.
  - With `rsp_ready` high on entry to RESPOND, `rsp_valid` is a one-cycle pulse.
- **Simultaneous requests:** exactly one grant per acceptance. With all requesters valid, grants rotate 0,1,2,3,0,…
- **Back-pressure:** `rsp_ready` low holds RESPOND indefinitely; no new acceptance occurs meanwhile.
- **Arbitration timing:** a `req_valid` that drops in the same cycle the FSM is in IDLE simply does not win; the arbiter is purely combinational on the current `req_valid`.

## Structure
- The shared `ImageProcessingPkg` keeps `instruction_t`, `pixelMatrix_t` and `opcodes_t` unchanged.
- `ImageProcessingPkg` gains a new `sched_state_t` enum (IDLE, ISSUE, WAIT, RESPOND).
- One sub-module, `rr_arbiter`:
  - parameter `NUM_REQ`;
  - inputs `req`, `ptr`;
  - outputs one-hot `grant`, `grant_idx` and `any`;
  - combinational only.
- The scheduler instantiates `rr_arbiter` and is itself instantiated alongside `ImageProcessor`, with `core_iw`→`IW` and `result`→`core_result`.

## Test plan
- **Single request:** reset, then requester 2 asserts ADD of cellA=all `000000` and cellB=all `00FF00`.
  - `req_ready[2]` is high in IDLE for 1 cycle.
  - `rsp_valid` rises `CORE_LATENCY`+1 cycles after acceptance, with `rsp_id`=2 and `rsp_result` all `00FF00`.
- **Round robin:** requesters 0–3 all hold `req_valid` with `rsp_ready`=1.
  - Grant order is 0,1,2,3,0.
  - Accept-to-accept spacing is exactly `CORE_LATENCY`+3 cycles.
- **Back-pressure:** hold `rsp_ready`=0 for 10 cycles in RESPOND.
  - `rsp_valid`, `rsp_id` and `rsp_result` remain stable.
  - `req_ready` stays 0.
  - After `rsp_ready`=1, IDLE follows on the next edge.
- **IW stability:** change `req_iw[winner]` to cellB=all `FF0000` during ISSUE/WAIT. `core_iw` keeps the originally accepted word until capture.
- **Reset mid-WAIT:** assert `reset_n`=0 during WAIT.
  - All outputs reach 0 asynchronously.
  - After release, a new request is served with `rsp_id` reflecting a `rr_ptr`=0 search and no stale response.
- **Sparse requests:** only requester 3 is valid after requester 1 was served. Requester 3 wins immediately (wrap search from `rr_ptr`=2).
